// File: rtl/jtag_dtm_tap.sv
// jtag_dtm_tap: the SoC-side JTAG Debug Transport Module.
// The JTAG pins are oversampled in the clk domain. The module runs the
// 1149.1 TAP controller and provides the IDCODE, DTMCS, DMI and BYPASS
// data registers. A completed DMI scan is turned into a valid/ready
// request toward the debug module.
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE      = 32'h1000_0A6F,
    parameter int          ABITS       = 7,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tck_i,
    input  logic               tms_i,
    input  logic               tdi_i,
    output logic               tdo_o,
    output logic               dmi_req_valid_o,
    input  logic               dmi_req_ready_i,
    output logic [ABITS+33:0]  dmi_req_o,
    input  logic               dmi_resp_valid_i,
    input  logic [33:0]        dmi_resp_i,
    output logic               dmi_hard_reset_o
);

    localparam int          DMI_W     = ABITS + 34;
    localparam logic [4:0]  IR_IDCODE = 5'h01;
    localparam logic [4:0]  IR_DTMCS  = 5'h10;
    localparam logic [4:0]  IR_DMI    = 5'h11;
    localparam logic [5:0]  ABITS_F   = 6'(ABITS);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_t;

    // ---------------------------------------------------------------
    // Pin synchronisers and TCK edge detection
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
    logic tck_prev;
    logic tck_s, tms_s, tdi_s;
    logic tck_rise, tck_fall;

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

    // Shift the JTAG pins through flop chains; keep the last synced TCK.
    always_ff @(posedge clk) begin
        if (reset) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck_i};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms_i};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi_i};
            tck_prev <= tck_s;
        end
    end

    // ---------------------------------------------------------------
    // TAP controller; tap_state is the observable controller state
    // ---------------------------------------------------------------
    tap_state_t tap_state, state_next;

    // TAP state register.
    always_ff @(posedge clk) begin
        if (reset) tap_state <= TLR;
        else       tap_state <= state_next;
    end

    // Standard 1149.1 transitions, taken only on a detected TCK rise.
    always_comb begin
        state_next = tap_state;
        if (tck_rise) begin
            case (tap_state)
                TLR:      state_next = tms_s ? TLR      : RTI;
                RTI:      state_next = tms_s ? SEL_DR   : RTI;
                SEL_DR:   state_next = tms_s ? SEL_IR   : CAP_DR;
                CAP_DR:   state_next = tms_s ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR: state_next = tms_s ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR: state_next = tms_s ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_next = tms_s ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR: state_next = tms_s ? UPD_DR   : SHIFT_DR;
                UPD_DR:   state_next = tms_s ? SEL_DR   : RTI;
                SEL_IR:   state_next = tms_s ? TLR      : CAP_IR;
                CAP_IR:   state_next = tms_s ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR: state_next = tms_s ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR: state_next = tms_s ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_next = tms_s ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR: state_next = tms_s ? UPD_IR   : SHIFT_IR;
                UPD_IR:   state_next = tms_s ? SEL_DR   : RTI;
                default:  state_next = TLR;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Instruction and data registers
    // ---------------------------------------------------------------
    logic [4:0]       ir, ir_shift;
    logic [DMI_W-1:0] dr_shift, dr_shifted, dr_capture;
    dr_sel_t          dr_sel;

    // DMI-side state used by the capture path.
    logic             busy;
    logic [1:0]       sticky;
    logic [ABITS-1:0] last_addr;
    logic [31:0]      resp_data;

    // A response landing in the same cycle as a capture is treated as
    // already complete, so the scan sees its data and resulting status.
    logic        resp_now, resp_failed, busy_eff;
    logic [31:0] data_eff;
    logic [1:0]  sticky_eff;

    assign resp_now    = dmi_resp_valid_i & busy;
    assign resp_failed = resp_now & (dmi_resp_i[1:0] != 2'd0);
    assign busy_eff    = busy & ~dmi_resp_valid_i;
    assign data_eff    = resp_now ? dmi_resp_i[33:2] : resp_data;
    assign sticky_eff  = resp_failed ? 2'd2 : sticky;

    // Select the data register addressed by the current instruction.
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir)
            IR_IDCODE: dr_sel = DR_IDCODE;
            IR_DTMCS:  dr_sel = DR_DTMCS;
            IR_DMI:    dr_sel = DR_DMI;
            default:   dr_sel = DR_BYPASS;
        endcase
    end

    // Capture value and one-bit right shift for the selected DR length.
    always_comb begin
        dr_capture = '0;
        dr_shifted = dr_shift;
        case (dr_sel)
            DR_IDCODE: begin
                dr_capture[31:0] = IDCODE;
                dr_shifted[31:0] = {tdi_s, dr_shift[31:1]};
            end
            DR_DTMCS: begin
                dr_capture[31:0] = {14'd0, 1'b0, 1'b0, 1'b0, 3'd1,
                                    sticky_eff, ABITS_F, 4'd1};
                dr_shifted[31:0] = {tdi_s, dr_shift[31:1]};
            end
            DR_DMI: begin
                dr_capture = {last_addr, data_eff,
                              busy_eff ? 2'd3 : sticky_eff};
                dr_shifted = {tdi_s, dr_shift[DMI_W-1:1]};
            end
            default: begin
                dr_shifted[0] = tdi_s;
            end
        endcase
    end

    // IR/DR capture and shift on TCK rise; TDO and Update-IR on TCK fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
            dr_shift <= '0;
            tdo_o    <= 1'b0;
        end else begin
            if (tap_state == TLR) ir <= IR_IDCODE;
            if (tck_rise) begin
                case (tap_state)
                    CAP_IR:   ir_shift <= 5'b00001;
                    SHIFT_IR: ir_shift <= {tdi_s, ir_shift[4:1]};
                    CAP_DR:   dr_shift <= dr_capture;
                    SHIFT_DR: dr_shift <= dr_shifted;
                    default:  ;
                endcase
            end
            if (tck_fall) begin
                case (tap_state)
                    SHIFT_IR: tdo_o <= ir_shift[0];
                    SHIFT_DR: tdo_o <= dr_shift[0];
                    UPD_IR:   ir    <= ir_shift;
                    default:  ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // DMI request / response side
    // ---------------------------------------------------------------
    logic             cap_dmi_evt, upd_dr_evt;
    logic [1:0]       upd_op;
    logic [31:0]      upd_data;
    logic [ABITS-1:0] upd_addr;
    logic             upd_is_access;

    assign cap_dmi_evt   = tck_rise & (tap_state == CAP_DR) & (dr_sel == DR_DMI);
    assign upd_dr_evt    = tck_fall & (tap_state == UPD_DR);
    assign upd_op        = dr_shift[1:0];
    assign upd_data      = dr_shift[33:2];
    assign upd_addr      = dr_shift[DMI_W-1:34];
    assign upd_is_access = (upd_op == 2'd1) || (upd_op == 2'd2);

    // Handshake: dmi_req_valid_o stays high with dmi_req_o frozen until the
    // first cycle where dmi_req_ready_i is also high; a transfer happens in
    // that cycle and valid drops on the next edge. busy then covers the
    // interval until the single-cycle dmi_resp_valid_i strobe.
    // Later assignments in this block take priority over earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmi_req_valid_o  <= 1'b0;
            dmi_req_o        <= '0;
            dmi_hard_reset_o <= 1'b0;
            busy             <= 1'b0;
            sticky           <= 2'd0;
            last_addr        <= '0;
            resp_data        <= '0;
        end else begin
            dmi_hard_reset_o <= 1'b0;
            if (dmi_req_valid_o && dmi_req_ready_i) dmi_req_valid_o <= 1'b0;
            if (resp_now) begin
                busy      <= 1'b0;
                resp_data <= dmi_resp_i[33:2];
                if (resp_failed) sticky <= 2'd2;
            end
            if (cap_dmi_evt && busy_eff) sticky <= 2'd3;
            if (upd_dr_evt) begin
                case (dr_sel)
                    DR_DTMCS: begin
                        if (dr_shift[17]) begin
                            sticky           <= 2'd0;
                            busy             <= 1'b0;
                            dmi_req_valid_o  <= 1'b0;
                            dmi_hard_reset_o <= 1'b1;
                        end else if (dr_shift[16]) begin
                            sticky <= 2'd0;
                        end
                    end
                    DR_DMI: begin
                        if (upd_is_access) begin
                            if (busy) begin
                                sticky <= 2'd3;
                            end else if (sticky == 2'd0) begin
                                dmi_req_o       <= {upd_addr, upd_data, upd_op};
                                dmi_req_valid_o <= 1'b1;
                                busy            <= 1'b1;
                                last_addr       <= upd_addr;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (tap_state == TLR) sticky <= 2'd0;
        end
    end

endmodule

// File: doc/jtag_dtm_tap.md
# jtag_dtm_tap

JTAG Debug Transport Module on the SoC side of the debug link: the responder to the host-side JTAG driver. It oversamples `tck_i`/`tms_i`/`tdi_i` in the core clock domain and runs the IEEE 1149.1 TAP state machine. It implements the RISC-V DTM registers (IDCODE, DTMCS, DMI, BYPASS) and turns completed DMI scans into valid/ready requests toward the debug module that drives the core debug FSM.

## Interface
- `IDCODE`, 32'h1000_0A6F: value captured for the IDCODE instruction; bit 0 must be 1.
- `ABITS`, 7: DMI address width.
- `SYNC_STAGES`, 2: synchronizer depth on the JTAG inputs; minimum 2.

- `clk` in 1: single system clock; all logic runs on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tck_i` in 1: JTAG TCK; asynchronous to `clk`, sampled.
- `tms_i` in 1: JTAG TMS.
- `tdi_i` in 1: JTAG TDI.
- `tdo_o` out 1: JTAG TDO; always driven.
- `dmi_req_valid_o` out 1: DMI request valid.
- `dmi_req_ready_i` in 1: DMI request accepted.
- `dmi_req_o` out ABITS+34: request bits {addr[ABITS-1:0], data[31:0], op[1:0]}, where op 1 = read and 2 = write.
- `dmi_resp_valid_i` in 1: one-cycle response strobe.
- `dmi_resp_i` in 34: response bits {data[31:0], resp[1:0]}, where resp 0 = ok and 2 = failed.
- `dmi_hard_reset_o` out 1: one-`clk` pulse requesting a debug-module reset.

## Operation
- **Input sampling.** `tck_i`, `tms_i` and `tdi_i` each pass through a SYNC_STAGES flop chain. A rising TCK edge (`tck_rise`) is detected when the synced TCK is high and its previous value was low; `tck_fall` is the inverse. TMS and TDI are used as synced values.
- **TAP FSM.** The 16 standard states advance only on `tck_rise`, steered by TMS. Five consecutive `tck_rise` with TMS=1 reach Test-Logic-Reset from any state.
- **Test-Logic-Reset.** IR is loaded with 5'h01 (IDCODE), the DMI sticky status is cleared, and no DMI request is issued.
- **IR path.** The IR is 5 bits.
  - Capture-IR loads the shift register with 5'b00001.
  - Shift-IR shifts right, with TDI entering the MSB.
  - Update-IR copies the shift register into IR.
- **Instruction decode and Capture-DR contents:**
  - IR 5'h01 (IDCODE), 32-bit DR: captures `IDCODE`.
  - IR 5'h10 (DTMCS), 32-bit DR: captures {14'b0, dmihardreset=0, dmireset=0, 1'b0, idle=3'd1, dmistat[1:0], abits[5:0]=ABITS, version=4'd1}.
  - IR 5'h11 (DMI), ABITS+34-bit DR: captures {last addr, last response data, op}. The op field is the sticky status, or 3 if a request is outstanding.
  - Any other IR value selects BYPASS, a 1-bit DR that captures 0.
- **Shift-DR.** Shifts the selected DR right, with TDI entering its MSB.
- **Update-DR actions.** These take effect on the `tck_fall` observed while in Update-DR.
  - DTMCS bit 16 (dmireset) clears the sticky status.
  - DTMCS bit 17 (dmihardreset) clears the sticky status, drops any outstanding request, and pulses `dmi_hard_reset_o` for one `clk`.
  - DMI with op 1 or 2, sticky = 0 and not busy: latch {addr, data, op} into `dmi_req_o`, set busy, assert `dmi_req_valid_o`.
  - DMI with op 1 or 2 while busy: sticky = 3 (busy); no request is issued.
  - DMI with op 1 or 2 while sticky ≠ 0: ignored.
  - DMI with op 0: no action.
- **Handshake.** `dmi_req_valid_o` holds, with `dmi_req_o` stable, until the cycle with `dmi_req_ready_i`=1. Busy remains set until `dmi_resp_valid_i`.
- **Response.** On `dmi_resp_valid_i`, the response data is latched and busy is cleared. If resp ≠ 0, sticky is set to 2.
- **Capture during busy.** A DMI Capture-DR while busy sets sticky = 3.
- **TDO.** On `tck_fall` in Shift-IR or Shift-DR, `tdo_o` is loaded with the LSB of the active shift register; otherwise it holds.

## Timing
- **Reset values:** TAP in Test-Logic-Reset, IR = 5'h01, `tdo_o` = 0, `dmi_req_valid_o` = 0, `dmi_req_o` = 0, `dmi_hard_reset_o` = 0, sticky = 0, busy = 0.
- **Reset mid-operation:** reset mid-scan or mid-request aborts everything; a pending response arriving afterward is ignored.
- **Clock ratio:** `clk` must be ≥ 4× TCK. Input-to-edge-detect latency is SYNC_STAGES+1 `clk` cycles.
- **Request timing:** `dmi_req_valid_o` rises in the `clk` cycle after the Update-DR `tck_fall` is detected. It falls in the cycle after the ready handshake.
- **Hard reset timing:** `dmi_hard_reset_o` is high for exactly one cycle, in the cycle after the Update-DR `tck_fall`.
- **Simultaneous events:** a response arriving in the same cycle as a DMI Capture-DR is captured as complete, with op reflecting the new sticky status. A response and a new request cannot coincide because busy blocks new requests.
- **Default DR after TLR:** the first Shift-DR after TLR returns `IDCODE`, LSB first.

## Test plan
- **IDCODE after reset:** reset; 5×TMS=1, then Run-Test/Idle → Shift-DR; shift 32 bits → TDO stream equals 32'h1000_0A6F, LSB first.
- **DTMCS read:** IR=5'h10; capture and shift 32 bits → 32'h0000_1071 (idle=1, abits=7, version=1, dmistat=0).
- **DMI write:** IR=5'h11; shift {addr 7'h10, data 32'h0000_0001, op 2}; Update-DR → next `clk` `dmi_req_valid_o`=1 with the same fields; hold `dmi_req_ready_i`=0 for 3 cycles → valid and fields stable; ready=1 → valid drops next cycle.
- **Busy and dmireset:** send a DMI read and withhold the response; issue a second DMI scan → captured op=3, no second request; deliver response {32'hCAFE_F00D, 0}; write DTMCS dmireset → sticky cleared; next DMI capture → data 32'hCAFE_F00D, op 0.
- **Failed response and hard reset:** a response with resp=2 sets dmistat=2 in DTMCS; writing dmihardreset produces a single `dmi_hard_reset_o` pulse and dmistat=0.
- **TMS reset and sync reset:** from Shift-DR, 5×TMS=1 → IR=5'h01 and BYPASS is not selected. Separately, asserting `reset` mid-shift → `tdo_o`=0 and all outputs at their reset values the next cycle.
